// File: rtl/hamming_pkg.sv
// Constants shared by the Hamming(7,4) receive path: deframer, decoder, encoder/serialiser.
// Holds codeword/data widths and the deframer state encoding.
// No logic lives here.
package hamming_pkg;

   localparam int HAM_CW_WIDTH   = 7;
   localparam int HAM_DATA_WIDTH = 4;

   // Deframer state encoding, kept numeric so other blocks and debug tools agree on it
   localparam logic [1:0] RX_IDLE = 2'd0;
   localparam logic [1:0] RX_DATA = 2'd1;
   localparam logic [1:0] RX_STOP = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = RX_IDLE,
      ST_DATA = RX_DATA,
      ST_STOP = RX_STOP
   } rx_state_t;

endpackage

// File: rtl/hamming_rx_deframer.sv
// Recovers 7-bit codewords from a start/stop framed serial line and hands them to the decoder.
// Latency: codeword valid one clk after the stop-bit strobe; frame_err pulses on that same clk.
// Backpressure: one-entry valid/ready buffer; a good frame arriving while it is full is dropped and sets sticky overrun.
module hamming_rx_deframer
   import hamming_pkg::*;
#(
   parameter int CW_WIDTH  = HAM_CW_WIDTH,
   // Must satisfy 2**CNT_WIDTH >= CW_WIDTH
   parameter int CNT_WIDTH = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                bit_en,
   input  logic                rx_bit,
   output logic [CW_WIDTH-1:0] cw_data,
   output logic                cw_valid,
   input  logic                cw_ready,
   output logic                frame_err,
   output logic                overrun,
   input  logic                clr_overrun
);

   localparam logic [CNT_WIDTH-1:0] LAST_BIT = CNT_WIDTH'(CW_WIDTH - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

   rx_state_t             state;
   logic [CNT_WIDTH-1:0]  bit_cnt;
   logic [CW_WIDTH-1:0]   shift_reg;

   logic                  stop_ok;
   logic                  xfer;
   logic                  buf_free;

   // A good stop bit on a strobe means the shift register holds a complete codeword
   assign stop_ok  = bit_en && (state == ST_STOP) && rx_bit;
   assign xfer     = cw_valid && cw_ready;
   // The buffer can take a new word if empty or being drained on this very edge
   assign buf_free = !cw_valid || cw_ready;

   // Framing FSM: hunt for start bit, shift codeword MSB first, then judge the stop bit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         bit_cnt   <= '0;
         shift_reg <= '0;
         frame_err <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         if (bit_en) begin
            case (state)
               ST_IDLE: begin
                  if (!rx_bit) begin
                     state   <= ST_DATA;
                     bit_cnt <= '0;
                  end
               end
               ST_DATA: begin
                  // No start-bit check here: a 0 mid-frame is just data
                  shift_reg <= {shift_reg[CW_WIDTH-2:0], rx_bit};
                  bit_cnt   <= bit_cnt + CNT_ONE;
                  if (bit_cnt == LAST_BIT) begin
                     state <= ST_STOP;
                  end
               end
               ST_STOP: begin
                  // Either way the next strobe may already carry a start bit
                  state     <= ST_IDLE;
                  frame_err <= !rx_bit;
               end
               default: begin
                  state <= ST_IDLE;
               end
            endcase
         end
      end
   end

   // Output buffer and overrun flag; a bad frame never reaches this block
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cw_data  <= '0;
         cw_valid <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         if (stop_ok && buf_free) begin
            cw_data  <= shift_reg;
            cw_valid <= 1'b1;
         end else if (xfer) begin
            cw_valid <= 1'b0;
         end

         // Set beats clear when both land on the same edge
         if (stop_ok && !buf_free) begin
            overrun <= 1'b1;
         end else if (clr_overrun) begin
            overrun <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_hamming_rx_deframer.sv
// Self-checking bench for hamming_rx_deframer.
// Frame-level reference model plus table vectors and directed corner sequences.
// Inputs driven 1 time unit after the rising edge, outputs sampled at the same point.
module tb_hamming_rx_deframer;
   import hamming_pkg::*;

   localparam int W = HAM_CW_WIDTH;

   logic         clk         = 1'b0;
   logic         rst_n       = 1'b0;
   logic         bit_en      = 1'b0;
   logic         rx_bit      = 1'b1;
   logic         cw_ready    = 1'b0;
   logic         clr_overrun = 1'b0;
   logic [W-1:0] cw_data;
   logic         cw_valid;
   logic         frame_err;
   logic         overrun;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state: where we are in the frame, and the downstream buffer
   bit m_in_frame;
   int m_bits;
   int m_val;
   bit m_valid;
   int m_data;
   bit m_ovr;
   bit m_err;

   // Observed downstream transfers
   int n_xfer      = 0;
   int last_xfer   = 0;
   int n_err_pulse = 0;

   // Stimulus knobs
   int gap_min = 0;
   int gap_max = 0;
   bit rdy_lvl = 1'b1;
   bit rand_hs = 1'b0;

   typedef struct {
      int cw;
      bit stop;
      bit exp_valid;
      bit exp_err;
      int exp_data;
   } vec_t;

   vec_t vecs[7];

   always #5 clk = ~clk;

   hamming_rx_deframer #(
      .CW_WIDTH  (W),
      .CNT_WIDTH (3)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bit_en      (bit_en),
      .rx_bit      (rx_bit),
      .cw_data     (cw_data),
      .cw_valid    (cw_valid),
      .cw_ready    (cw_ready),
      .frame_err   (frame_err),
      .overrun     (overrun),
      .clr_overrun (clr_overrun)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_in_frame = 1'b0;
      m_bits     = 0;
      m_val      = 0;
      m_valid    = 1'b0;
      m_data     = 0;
      m_ovr      = 1'b0;
      m_err      = 1'b0;
   endtask

   // Advance the model by one clock given the inputs present during that clock
   task automatic model_step(input logic en, input logic rx, input logic rdy, input logic clr);
      bit deliver;
      bit ovr_set;
      deliver = 1'b0;
      ovr_set = 1'b0;
      m_err   = 1'b0;
      if (en) begin
         if (!m_in_frame) begin
            if (rx == 1'b0) begin
               m_in_frame = 1'b1;
               m_bits     = 0;
               m_val      = 0;
            end
         end else if (m_bits < W) begin
            m_val  = m_val * 2 + int'(rx);
            m_bits = m_bits + 1;
         end else begin
            if (rx) deliver = 1'b1;
            else    m_err   = 1'b1;
            m_in_frame = 1'b0;
         end
      end
      if (deliver) begin
         if (!m_valid || rdy) begin
            m_data  = m_val;
            m_valid = 1'b1;
         end else begin
            ovr_set = 1'b1;
         end
      end else if (m_valid && rdy) begin
         m_valid = 1'b0;
      end
      if (ovr_set)  m_ovr = 1'b1;
      else if (clr) m_ovr = 1'b0;
   endtask

   // One clock: drive, advance model, then compare every output
   task automatic step(input logic en, input logic rx, input logic rdy, input logic clr);
      bit_en      = en;
      rx_bit      = rx;
      cw_ready    = rdy;
      clr_overrun = clr;
      if (cw_valid && rdy) begin
         n_xfer++;
         last_xfer = int'(cw_data);
      end
      model_step(en, rx, rdy, clr);
      @(posedge clk);
      #1;
      if (frame_err) n_err_pulse++;
      check("cyc_valid", cw_valid, m_valid);
      check("cyc_data", cw_data, m_data);
      check("cyc_frame_err", frame_err, m_err);
      check("cyc_overrun", overrun, m_ovr);
   endtask

   function automatic logic cur_rdy();
      if (rand_hs) return logic'($urandom_range(1, 0));
      return rdy_lvl;
   endfunction

   function automatic logic cur_clr();
      if (rand_hs) return ($urandom_range(15, 0) == 0);
      return 1'b0;
   endfunction

   task automatic send_bit(input logic b);
      int g;
      g = $urandom_range(gap_max, gap_min);
      repeat (g) step(1'b0, b, cur_rdy(), cur_clr());
      step(1'b1, b, cur_rdy(), cur_clr());
   endtask

   task automatic send_data(input int val);
      send_bit(1'b0);
      for (int i = W - 1; i >= 0; i--) send_bit(logic'((val >> i) & 1));
   endtask

   task automatic send_frame(input int val, input logic stop);
      send_data(val);
      send_bit(stop);
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 1'b1, cur_rdy(), 1'b0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int x0;
      int e0;
      int v;

      vecs[0] = '{cw: 'h01, stop: 1'b1, exp_valid: 1'b1, exp_err: 1'b0, exp_data: 'h01};
      vecs[1] = '{cw: 'h40, stop: 1'b1, exp_valid: 1'b1, exp_err: 1'b0, exp_data: 'h40};
      vecs[2] = '{cw: 'h5A, stop: 1'b0, exp_valid: 1'b0, exp_err: 1'b1, exp_data: 'h40};
      vecs[3] = '{cw: 'h7F, stop: 1'b1, exp_valid: 1'b1, exp_err: 1'b0, exp_data: 'h7F};
      vecs[4] = '{cw: 'h00, stop: 1'b1, exp_valid: 1'b1, exp_err: 1'b0, exp_data: 'h00};
      vecs[5] = '{cw: 'h2B, stop: 1'b0, exp_valid: 1'b0, exp_err: 1'b1, exp_data: 'h00};
      vecs[6] = '{cw: 'h63, stop: 1'b1, exp_valid: 1'b1, exp_err: 1'b0, exp_data: 'h63};

      // Reset state
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", cw_valid, 1'b0);
      check("rst_data", cw_data, 0);
      check("rst_frame_err", frame_err, 1'b0);
      check("rst_overrun", overrun, 1'b0);
      rst_n = 1'b1;
      idle(2);

      // Table vectors, downstream always ready
      rdy_lvl = 1'b1;
      gap_min = 2;
      gap_max = 2;
      for (int i = 0; i < 7; i++) begin
         send_frame(vecs[i].cw, vecs[i].stop);
         check("tbl_valid", cw_valid, vecs[i].exp_valid);
         check("tbl_frame_err", frame_err, vecs[i].exp_err);
         check("tbl_data", cw_data, vecs[i].exp_data);
         check("tbl_overrun", overrun, 1'b0);
      end
      idle(2);

      // 0x55 with a strobe every 4th clk: valid for exactly one clk after the stop strobe
      gap_min = 3;
      gap_max = 3;
      send_data('h55);
      repeat (3) step(1'b0, 1'b1, 1'b1, 1'b0);
      check("t1_pre_stop_valid", cw_valid, 1'b0);
      x0 = n_xfer;
      step(1'b1, 1'b1, 1'b1, 1'b0);
      check("t1_valid", cw_valid, 1'b1);
      check("t1_data", cw_data, 'h55);
      step(1'b0, 1'b1, 1'b1, 1'b0);
      check("t1_valid_drop", cw_valid, 1'b0);
      check("t1_xfer_cnt", n_xfer - x0, 1);
      check("t1_xfer_data", last_xfer, 'h55);

      // Bad stop bit, then a good frame
      send_frame('h33, 1'b0);
      check("t2_frame_err", frame_err, 1'b1);
      check("t2_valid", cw_valid, 1'b0);
      check("t2_overrun", overrun, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b0);
      check("t2_err_pulse_end", frame_err, 1'b0);
      send_frame('h0F, 1'b1);
      check("t2_good_valid", cw_valid, 1'b1);
      check("t2_good_data", cw_data, 'h0F);
      idle(2);

      // Full buffer: second frame dropped, overrun raised, then drain and clear
      rdy_lvl = 1'b0;
      gap_min = 1;
      gap_max = 1;
      send_frame('h12, 1'b1);
      send_frame('h34, 1'b1);
      check("t3_data_held", cw_data, 'h12);
      check("t3_valid", cw_valid, 1'b1);
      check("t3_overrun", overrun, 1'b1);
      x0 = n_xfer;
      step(1'b0, 1'b1, 1'b1, 1'b0);
      check("t3_drained", cw_valid, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b0);
      check("t3_xfer_cnt", n_xfer - x0, 1);
      check("t3_xfer_data", last_xfer, 'h12);
      check("t3_overrun_sticky", overrun, 1'b1);
      step(1'b0, 1'b1, 1'b0, 1'b1);
      check("t3_overrun_clr", overrun, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0);

      // Back-to-back: ready only on the deliver clk of the next frame, no gap in valid
      gap_min = 0;
      gap_max = 0;
      send_frame('h55, 1'b1);
      check("t4_first", cw_data, 'h55);
      send_data('h2A);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      check("t4_valid", cw_valid, 1'b1);
      check("t4_data", cw_data, 'h2A);
      check("t4_overrun", overrun, 1'b0);
      check("t4_xfer_data", last_xfer, 'h55);

      // Reset after the 3rd data bit
      gap_min = 1;
      gap_max = 1;
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      rst_n  = 1'b0;
      bit_en = 1'b0;
      rx_bit = 1'b1;
      #1;
      check("t5_rst_valid", cw_valid, 1'b0);
      check("t5_rst_data", cw_data, 0);
      check("t5_rst_frame_err", frame_err, 1'b0);
      check("t5_rst_overrun", overrun, 1'b0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("t5_rst_hold_valid", cw_valid, 1'b0);
      rst_n   = 1'b1;
      rdy_lvl = 1'b1;
      x0 = n_xfer;
      send_frame('h7F, 1'b1);
      idle(3);
      check("t5_xfer_cnt", n_xfer - x0, 1);
      check("t5_xfer_data", last_xfer, 'h7F);

      // Idle line, then a frame with random strobe gaps
      e0 = n_err_pulse;
      x0 = n_xfer;
      repeat (20) send_bit(1'b1);
      check("t6_idle_err", n_err_pulse - e0, 0);
      check("t6_idle_xfer", n_xfer - x0, 0);
      check("t6_idle_valid", cw_valid, 1'b0);
      gap_min = 0;
      gap_max = 6;
      v = $urandom_range(127, 0);
      send_frame(v, 1'b1);
      idle(2);
      check("t6_xfer_cnt", n_xfer - x0, 1);
      check("t6_xfer_data", last_xfer, v);

      // Random frames, random gaps, random handshake and clears
      rand_hs = 1'b1;
      gap_min = 0;
      gap_max = 3;
      for (int i = 0; i < 40; i++) begin
         v = $urandom_range(127, 0);
         send_frame(v, logic'($urandom_range(7, 0) != 0));
         idle($urandom_range(3, 0));
      end
      rand_hs = 1'b0;
      rdy_lvl = 1'b1;
      idle(3);
      check("end_drained", cw_valid, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
